// File: rtl/display_pkg.sv
// Shared display package.
// Holds the digit geometry constants and the small types that the scan
// controller and the downstream anode decoder agree on.
//   DIGIT_W     bits per displayed hex digit
//   MAX_DIGITS  largest display supported by the 3-bit digit index
//   digit_idx_t digit index driven to the 3-to-8 anode decoder
//   nibble_t    one hex digit value for the segment encoder
//   word_t      full packed display word, digit 0 in the low nibble
package display_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;

  typedef logic [2:0]                      digit_idx_t;
  typedef logic [DIGIT_W-1:0]              nibble_t;
  typedef logic [MAX_DIGITS*DIGIT_W-1:0]   word_t;

  // Nibble i of a display word lives at bits [4i+3:4i].
  function automatic nibble_t nibble_at(input word_t w, input digit_idx_t i);
    return w[{i, 2'b00} +: DIGIT_W];
  endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Bus between the display scanner and whoever owns the display word.
//
// Handshake: load is a single-cycle strobe with no ready/backpressure.
// value_in is meaningful only in a cycle where load is high; the scanner
// always accepts it. update_pending reports that an accepted word has not
// yet been committed to the display. All scanner outputs are driven from
// registers, so none depends combinationally on value_in or load.
//
// Signals:
//   value_in       32  display word, nibble i = value_in[4i+3:4i]
//   load            1  capture strobe for value_in
//   update_pending  1  a loaded word awaits its frame-boundary commit
//   digit_sel       3  current digit index (scan ring state)
//   digit_val       4  committed nibble at digit_sel
//   digit_blank     1  segment encoder must blank this digit
//   frame_done      1  pulse in the last cycle of each full scan
//
// Modports: master = word producer, slave = display_scanner.
interface display_scanner_if;
  import display_pkg::*;

  word_t      value_in;
  logic       load;
  logic       update_pending;
  digit_idx_t digit_sel;
  nibble_t    digit_val;
  logic       digit_blank;
  logic       frame_done;

  modport master (
    output value_in,
    output load,
    input  update_pending,
    input  digit_sel,
    input  digit_val,
    input  digit_blank,
    input  frame_done
  );

  modport slave (
    input  value_in,
    input  load,
    output update_pending,
    output digit_sel,
    output digit_val,
    output digit_blank,
    output frame_done
  );

endinterface

// File: rtl/refresh_prescaler.sv
// Refresh prescaler for the display scanner.
// Counts 0..DIV-1 and wraps; tick is high in the final count so each digit
// of the scan stays selected for exactly DIV cycles.
//   clk    system clock, rising edge
//   reset  synchronous, active-high; counter restarts at 0
//   tick   high while the counter holds DIV-1
module refresh_prescaler #(
  parameter int DIV = 100_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexing scan controller for an up-to-8-digit seven-segment
// display. Steps a digit index through the digits at a fixed refresh rate
// and presents the matching nibble of the committed display word. Loaded
// words are held in a shadow register and committed only at a frame
// boundary so no digit ever shows a torn value mid-scan.
//
// Parameters:
//   REFRESH_DIV  cycles each digit stays selected (>= 2)
//   NUM_DIGITS   digits scanned, 1..8
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    display_scanner_if.slave (value_in, load, update_pending,
//          digit_sel, digit_val, digit_blank, frame_done)
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  blank leading zero digits (digit 0 never blanked)
//
// The scan ring state is digit_sel itself (S0..S(N-1)), exposed on the bus.
module display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic               clk,
  input  logic               reset,
  display_scanner_if.slave   bus
);

  localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

  logic       tick;
  logic       frame_done;
  digit_idx_t digit_sel;
  word_t      shadow;
  word_t      disp;
  logic       pending;

  refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign frame_done = tick && (digit_sel == LAST_IDX);

  // Scan ring. With a single digit LAST_IDX is 0 so the index stays at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_sel <= '0;
    end else if (tick) begin
      if (digit_sel == LAST_IDX) begin
        digit_sel <= '0;
      end else begin
        digit_sel <= digit_sel + digit_idx_t'(1);
      end
    end
  end

  // Shadow/commit. A load in the frame_done cycle bypasses the shadow and
  // lands in disp directly; the commit clear overrides the load's set, so
  // pending never rises for that load.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else begin
      if (bus.load) begin
        shadow  <= bus.value_in;
        pending <= 1'b1;
      end
      if (frame_done && (pending || bus.load)) begin
        disp    <= bus.load ? bus.value_in : shadow;
        pending <= 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the top scanned digit down; a digit is blank while every
  // nibble from it upward is zero. Digit 0 always shows.
  logic [MAX_DIGITS-1:0] blank_mask;
  logic                  zero_above;

  always_comb begin
    blank_mask = '0;
    zero_above = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < NUM_DIGITS) begin
        zero_above    = zero_above && (nibble_at(disp, digit_idx_t'(i)) == '0);
        blank_mask[i] = zero_above && (i != 0);
      end
    end
  end

  assign bus.digit_blank = blank_mask[digit_sel];
`else
  assign bus.digit_blank = 1'b0;
`endif

  assign bus.digit_sel      = digit_sel;
  assign bus.digit_val      = nibble_at(disp, digit_sel);
  assign bus.frame_done     = frame_done;
  assign bus.update_pending = pending;

endmodule

// File: tb/tb_display_scanner.sv
// Testbench for display_scanner (REFRESH_DIV=4, NUM_DIGITS=8).
// Inputs change on the falling edge; outputs are checked on the falling
// edge against a cycle-count model of the scan and a queue of loaded words
// awaiting commit. Builds with or without LEADING_ZERO_BLANK_EN.
module tb_display_scanner;
  import display_pkg::*;

  localparam int DIV   = 4;
  localparam int N     = 8;
  localparam int FRAME = DIV * N;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  display_scanner_if bus ();

  display_scanner #(
    .REFRESH_DIV (DIV),
    .NUM_DIGITS  (N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  int          m_cyc   = 0;     // cycles since reset release
  logic [31:0] m_disp  = '0;    // word currently on display
  bit          m_valid = 1'b0;
  logic [31:0] exp_q[$];        // loaded words not yet committed

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d)",
               name, act, exp, m_cyc);
    end
  endtask

  // Model: a frame ends every FRAME cycles; at that edge the newest loaded
  // word (including one loaded in that very cycle) becomes the display word.
  always @(posedge clk) begin
    if (reset) begin
      m_cyc   = 0;
      m_disp  = '0;
      exp_q.delete();
      m_valid = 1'b1;
    end else begin
      if (bus.load === 1'b1) exp_q.push_back(bus.value_in);
      if ((m_cyc % FRAME) == FRAME - 1 && exp_q.size() != 0) begin
        m_disp = exp_q[$];
        exp_q.delete();
      end
      m_cyc++;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      int          e_sel;
      logic [31:0] upper;
      e_sel = (m_cyc / DIV) % N;
      upper = m_disp >> (4 * e_sel);
      check("digit_sel", 32'(bus.digit_sel), 32'(e_sel));
      check("frame_done", 32'(bus.frame_done),
            32'((m_cyc % FRAME) == FRAME - 1));
      check("digit_val", 32'(bus.digit_val), upper & 32'hF);
      check("update_pending", 32'(bus.update_pending), 32'(exp_q.size() != 0));
      check("digit_blank", 32'(bus.digit_blank),
            32'(BLANK_EN && e_sel != 0 && upper == 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int c);
    int guard = 0;
    while (m_cyc != c && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (m_cyc != c) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_until: reached cycle %0d expected %0d", m_cyc, c);
    end
  endtask

  task automatic pulse_load(input logic [31:0] v);
    bus.load     = 1'b1;
    bus.value_in = v;
    @(negedge clk);
    bus.load     = 1'b0;
    bus.value_in = $urandom;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.load     = 1'b0;
    bus.value_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and scan timing
    wait_until(0);
    check("lit reset sel", 32'(bus.digit_sel), 0);
    check("lit reset val", 32'(bus.digit_val), 0);
    check("lit reset pend", 32'(bus.update_pending), 0);
    check("lit reset fd", 32'(bus.frame_done), 0);
    wait_until(3);
    check("lit sel c3", 32'(bus.digit_sel), 0);
    wait_until(4);
    check("lit sel c4", 32'(bus.digit_sel), 1);

    // Load 12345678 at cycle 5, commit at the cycle-31 edge
    wait_until(5);
    pulse_load(32'h1234_5678);
    check("lit pend c6", 32'(bus.update_pending), 1);
    wait_until(30);
    check("lit val pre-commit", 32'(bus.digit_val), 0);
    check("lit fd c30", 32'(bus.frame_done), 0);
    wait_until(31);
    check("lit fd c31", 32'(bus.frame_done), 1);
    check("lit pend c31", 32'(bus.update_pending), 1);
    wait_until(32);
    check("lit sel c32", 32'(bus.digit_sel), 0);
    check("lit val d0", 32'(bus.digit_val), 8);
    check("lit pend c32", 32'(bus.update_pending), 0);
    wait_until(60);
    check("lit sel c60", 32'(bus.digit_sel), 7);
    check("lit val d7", 32'(bus.digit_val), 1);

    // Last load before the boundary wins
    wait_until(70);
    pulse_load(32'hAAAA_AAAA);
    wait_until(75);
    pulse_load(32'h0000_00FF);
    wait_until(94);
    check("lit val old d7", 32'(bus.digit_val), 1);
    wait_until(96);
    check("lit ff d0", 32'(bus.digit_val), 32'hF);
    wait_until(100);
    check("lit ff d1", 32'(bus.digit_val), 32'hF);
    wait_until(104);
    check("lit ff d2", 32'(bus.digit_val), 0);

    // Load in the frame_done cycle commits immediately
    wait_until(127);
    check("lit fd c127", 32'(bus.frame_done), 1);
    pulse_load(32'hDEAD_BEEF);
    check("lit pend bypass", 32'(bus.update_pending), 0);
    check("lit beef d0", 32'(bus.digit_val), 32'hF);
    wait_until(156);
    check("lit dead d7", 32'(bus.digit_val), 32'hD);

    // Reset while pending at digit 5
    wait_until(165);
    pulse_load(32'h1111_1111);
    wait_until(180);
    check("lit sel c180", 32'(bus.digit_sel), 5);
    check("lit pend c180", 32'(bus.update_pending), 1);
    reset = 1'b1;
    @(negedge clk);
    check("lit rst sel", 32'(bus.digit_sel), 0);
    check("lit rst pend", 32'(bus.update_pending), 0);
    check("lit rst val", 32'(bus.digit_val), 0);
    reset = 1'b0;

    // Leading-zero blanking on 00000305, then on 0
    wait_until(2);
    pulse_load(32'h0000_0305);
    wait_until(36);
    check("lit blank d1", 32'(bus.digit_blank), 0);
    wait_until(40);
    check("lit val d2", 32'(bus.digit_val), 3);
    check("lit blank d2", 32'(bus.digit_blank), 0);
    wait_until(44);
    check("lit blank d3", 32'(bus.digit_blank), 32'(BLANK_EN));
    wait_until(50);
    pulse_load(32'h0);
    wait_until(64);
    check("lit zero blank d0", 32'(bus.digit_blank), 0);
    wait_until(68);
    check("lit zero blank d1", 32'(bus.digit_blank), 32'(BLANK_EN));

    // Randomized loads (varying leading zeros) with occasional resets
    for (int k = 0; k < 4000; k++) begin
      bus.load     = ($urandom_range(0, 9) == 0);
      bus.value_in = $urandom >> (4 * $urandom_range(0, 8));
      reset        = ($urandom_range(0, 799) == 0);
      @(negedge clk);
    end
    bus.load = 1'b0;
    reset    = 1'b0;
    repeat (FRAME + 2) @(negedge clk);
    apply_reset();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
